fptd_iter_ctrl: RTL and testbench

- Iteration scheduler for the fully-parallel turbo decoder (FPTD) processing-element array.
- Sequences each frame through these steps: LLR load, metric initialisation, alternating odd/even half-iterations, hard-decision capture and result handshake.
- Drives the enables that gate the alpha/beta/epsilon pipeline registers in odd-indexed and even-indexed trellis stages.
- Supports a programmable iteration limit, early termination and synchronous abort.

---
 rtl/fptd_iter_ctrl_if.sv | 31 +++
 rtl/fptd_iter_ctrl.sv | 82 ++++++++
 tb/tb_fptd_iter_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fptd_iter_ctrl_if.sv
// Control/status bundle between the FPTD iteration scheduler and its frame-level master.
interface fptd_iter_ctrl_if #(
  parameter int ITER_W = 6
);
  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              early_stop;
  logic              abort;
  logic              out_ready;
  logic              busy;
  logic              load_en;
  logic              init_metrics;
  logic              odd_en;
  logic              even_en;
  logic              decide_en;
  logic              out_valid;
  logic              early_term;
  logic [ITER_W-1:0] iter_count;

  modport master (
    output start, max_iter, early_stop, abort, out_ready,
    input  busy, load_en, init_metrics, odd_en, even_en, decide_en,
           out_valid, early_term, iter_count
  );

  modport slave (
    input  start, max_iter, early_stop, abort, out_ready,
    output busy, load_en, init_metrics, odd_en, even_en, decide_en,
           out_valid, early_term, iter_count
  );
endinterface

// File: rtl/fptd_iter_ctrl.sv
// Frame sequencer for the FPTD PE array: load, metric init, odd/even half-iterations,
// hard-decision capture and result handshake, with iteration limit, early stop and abort.
module fptd_iter_ctrl #(
  parameter int ITER_W = 6
) (
  input logic            Clock,
  input logic            nReset,
  fptd_iter_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_ODD    = 3'd3;
  localparam logic [2:0] S_EVEN   = 3'd4;
  localparam logic [2:0] S_DECIDE = 3'd5;
  localparam logic [2:0] S_OUTPUT = 3'd6;

  logic [2:0]        state;
  logic [ITER_W-1:0] lim;
  logic [ITER_W-1:0] iter_cnt;
  logic              early_term_r;
  logic              last_iter;

  // lim is never 0 once a frame runs, so lim-1 cannot underflow and the counter stops at lim
  assign last_iter = (iter_cnt == lim - ITER_W'(1));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state        <= S_IDLE;
      lim          <= '0;
      iter_cnt     <= '0;
      early_term_r <= 1'b0;
    end else if (bus.abort && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lim   <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          iter_cnt     <= '0;
          early_term_r <= 1'b0;
          state        <= S_INIT;
        end
        S_INIT: state <= S_ODD;
        S_ODD:  state <= S_EVEN;
        S_EVEN: begin
          iter_cnt <= iter_cnt + ITER_W'(1);
          if (last_iter) begin
            state <= S_DECIDE;
          end else if (bus.early_stop) begin
            early_term_r <= 1'b1;
            state        <= S_DECIDE;
          end else begin
            state <= S_ODD;
          end
        end
        S_DECIDE: state <= S_OUTPUT;
        S_OUTPUT: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output is a pure decode of registered state
  assign bus.busy         = (state != S_IDLE);
  assign bus.load_en      = (state == S_LOAD);
  assign bus.init_metrics = (state == S_INIT);
  assign bus.odd_en       = (state == S_ODD);
  assign bus.even_en      = (state == S_EVEN);
  assign bus.decide_en    = (state == S_DECIDE);
  assign bus.out_valid    = (state == S_OUTPUT);
  assign bus.early_term   = early_term_r;
  assign bus.iter_count   = iter_cnt;

endmodule

// File: tb/tb_fptd_iter_ctrl.sv
// Directed bench for fptd_iter_ctrl: cycle-by-cycle enable sequence and final status per frame.
module tb_fptd_iter_ctrl;

  localparam int ITER_W = 6;

  localparam logic [5:0] V_IDLE = 6'b000000;
  localparam logic [5:0] V_LOAD = 6'b100000;
  localparam logic [5:0] V_INIT = 6'b010000;
  localparam logic [5:0] V_ODD  = 6'b001000;
  localparam logic [5:0] V_EVEN = 6'b000100;
  localparam logic [5:0] V_DEC  = 6'b000010;
  localparam logic [5:0] V_OUT  = 6'b000001;

  logic Clock;
  logic nReset;
  int   total;
  int   passed;
  int   failed;

  fptd_iter_ctrl_if #(.ITER_W(ITER_W)) bus ();

  fptd_iter_ctrl #(.ITER_W(ITER_W)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [6:0] outs();
    return {bus.busy, bus.load_en, bus.init_metrics, bus.odd_en, bus.even_en,
            bus.decide_en, bus.out_valid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the enable vector (busy is implied by a non-idle vector)
  task automatic expect_cyc(input logic [5:0] v, input string tag);
    @(negedge Clock);
    chk(tag, {25'b0, outs()}, {25'b0, (v != 6'b0), v});
  endtask

  task automatic start_frame(input logic [ITER_W-1:0] mi, input string tag);
    bus.start    = 1'b1;
    bus.max_iter = mi;
    expect_cyc(V_LOAD, tag);
    bus.start = 1'b0;
  endtask

  task automatic run_pairs(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      expect_cyc(V_ODD, tag);
      expect_cyc(V_EVEN, tag);
    end
  endtask

  task automatic check_status(input int it, input logic et, input string tag);
    chk({tag, "_iter"}, {26'b0, bus.iter_count}, it);
    chk({tag, "_early"}, {31'b0, bus.early_term}, {31'b0, et});
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    nReset = 1'b0;
    bus.start = 1'b0; bus.max_iter = '0; bus.early_stop = 1'b0;
    bus.abort = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst_outs", {25'b0, outs()}, 32'h0);
    check_status(0, 1'b0, "rst");
    nReset = 1'b1;
    expect_cyc(V_IDLE, "rst_idle");

    // Frame 1: limit 3; max_iter changes after acceptance are ignored
    start_frame(6'd3, "f1_load");
    bus.max_iter = 6'd1;
    expect_cyc(V_INIT, "f1_init");
    run_pairs(3, "f1_run");
    expect_cyc(V_DEC, "f1_dec");
    expect_cyc(V_OUT, "f1_out");
    expect_cyc(V_IDLE, "f1_idle");
    check_status(3, 1'b0, "f1");

    // Frame 2: limit 10, early_stop in RUN_ODD ignored, in 2nd RUN_EVEN honoured
    start_frame(6'd10, "f2_load");
    expect_cyc(V_INIT, "f2_init");
    expect_cyc(V_ODD, "f2_odd1");
    bus.early_stop = 1'b1;
    expect_cyc(V_EVEN, "f2_even1");
    bus.early_stop = 1'b0;
    expect_cyc(V_ODD, "f2_odd2");
    expect_cyc(V_EVEN, "f2_even2");
    bus.early_stop = 1'b1;
    expect_cyc(V_DEC, "f2_dec");
    bus.early_stop = 1'b0;
    expect_cyc(V_OUT, "f2_out");
    expect_cyc(V_IDLE, "f2_idle");
    check_status(2, 1'b1, "f2");

    // Frame 3: max_iter 0 behaves as 1
    start_frame(6'd0, "f3_load");
    expect_cyc(V_INIT, "f3_init");
    run_pairs(1, "f3_run");
    expect_cyc(V_DEC, "f3_dec");
    expect_cyc(V_OUT, "f3_out");
    expect_cyc(V_IDLE, "f3_idle");
    check_status(1, 1'b0, "f3");

    // Frame 4: early_stop held from start ends after the first iteration
    bus.early_stop = 1'b1;
    start_frame(6'd4, "f4_load");
    expect_cyc(V_INIT, "f4_init");
    run_pairs(1, "f4_run");
    expect_cyc(V_DEC, "f4_dec");
    expect_cyc(V_OUT, "f4_out");
    expect_cyc(V_IDLE, "f4_idle");
    check_status(1, 1'b1, "f4");

    // Frame 5: limit reached together with early_stop -> limit wins, early_term 0
    start_frame(6'd1, "f5_load");
    check_status(1, 1'b1, "f5_hold");
    expect_cyc(V_INIT, "f5_init");
    check_status(0, 1'b0, "f5_clr");
    run_pairs(1, "f5_run");
    expect_cyc(V_DEC, "f5_dec");
    expect_cyc(V_OUT, "f5_out");
    expect_cyc(V_IDLE, "f5_idle");
    check_status(1, 1'b0, "f5");
    bus.early_stop = 1'b0;

    // Frame 6: limit 2, out_ready low for 5 OUTPUT cycles, start during OUTPUT ignored
    bus.out_ready = 1'b0;
    start_frame(6'd2, "f6_load");
    expect_cyc(V_INIT, "f6_init");
    run_pairs(2, "f6_run");
    expect_cyc(V_DEC, "f6_dec");
    for (int i = 0; i < 5; i++) begin
      expect_cyc(V_OUT, "f6_out_hold");
      bus.start = (i == 2) || (i == 4);
      if (i == 4) bus.out_ready = 1'b1;
    end
    expect_cyc(V_IDLE, "f6_idle");
    bus.start = 1'b0;
    expect_cyc(V_IDLE, "f6_no_load");
    check_status(2, 1'b0, "f6");

    // Frame 7: full-range limit 63 runs all iterations without wrap
    start_frame(6'd63, "f7_load");
    expect_cyc(V_INIT, "f7_init");
    run_pairs(63, "f7_run");
    expect_cyc(V_DEC, "f7_dec");
    expect_cyc(V_OUT, "f7_out");
    expect_cyc(V_IDLE, "f7_idle");
    check_status(63, 1'b0, "f7");

    // Frame 8: abort during the 20th RUN_ODD
    start_frame(6'd63, "f8_load");
    expect_cyc(V_INIT, "f8_init");
    run_pairs(19, "f8_run");
    expect_cyc(V_ODD, "f8_odd20");
    bus.abort = 1'b1;
    expect_cyc(V_IDLE, "f8_abort");
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) expect_cyc(V_IDLE, "f8_no_out");
    check_status(19, 1'b0, "f8");

    // Abort in IDLE has no effect on a following start
    bus.abort = 1'b1;
    expect_cyc(V_IDLE, "idle_abort");
    bus.abort = 1'b0;

    // Frame 9: asynchronous reset mid RUN_EVEN
    start_frame(6'd5, "f9_load");
    expect_cyc(V_INIT, "f9_init");
    expect_cyc(V_ODD, "f9_odd");
    expect_cyc(V_EVEN, "f9_even");
    #2 nReset = 1'b0;
    #1;
    chk("f9_async_outs", {25'b0, outs()}, 32'h0);
    check_status(0, 1'b0, "f9_async");
    @(negedge Clock);
    nReset = 1'b1;
    expect_cyc(V_IDLE, "f9_wait");
    expect_cyc(V_IDLE, "f9_wait2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
